// File: rtl/pea_pkg.sv
// Shared PE-array types and constants; the divider pulls its defaults,
// instruction encoding and FSM state type from here.
package pea_pkg;

  localparam int unsigned N_BITS      = 32;
  localparam int unsigned N_RADIX     = 16;
  localparam int unsigned N_DIV_STAGE = 8;

  localparam int unsigned DIV_BITS_PER_STAGE = $clog2(N_RADIX);
  // Consumed by an elaboration-time check in pe_radix16_div.
  localparam bit DIV_CFG_OK = (N_DIV_STAGE * DIV_BITS_PER_STAGE == N_BITS);

  typedef enum logic [2:0] {
    FU_NOP, FU_ADD, FU_SUB, FU_MUL, FU_DIV, FU_DIVU, FU_REM
  } fu_instr_t;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

endpackage

// File: rtl/pe_div_step.sv
// One CALC iteration: BPS chained restoring radix-2 steps, purely combinational.
module pe_div_step import pea_pkg::*; #(
  parameter int unsigned N_BITS = pea_pkg::N_BITS,
  parameter int unsigned BPS    = DIV_BITS_PER_STAGE
) (
  input  logic [N_BITS:0]   rem_i,
  input  logic [N_BITS-1:0] div_i,
  input  logic [BPS-1:0]    bits_i,
  output logic [N_BITS:0]   rem_o,
  output logic [BPS-1:0]    q_o
);

  logic [N_BITS:0] r, diff;

  // r stays below 2*divisor after the shift, so diff[N_BITS] is a true sign bit.
  always_comb begin
    r    = rem_i;
    diff = '0;
    q_o  = '0;
    for (int i = BPS - 1; i >= 0; i--) begin
      r      = {r[N_BITS-1:0], bits_i[i]};
      diff   = r - {1'b0, div_i};
      q_o[i] = ~diff[N_BITS];
      if (!diff[N_BITS]) r = diff;
    end
    rem_o = r;
  end

endmodule

// File: rtl/pe_radix16_div.sv
// Iterative radix-16 DIV/DIVU/REM unit with valid/ready on both sides.
// Define MAGE_DIV_EARLY_OUT_EN to let special cases and |A|<|B| skip CALC.
module pe_radix16_div import pea_pkg::*; #(
  parameter int unsigned N_BITS      = pea_pkg::N_BITS,
  parameter int unsigned N_RADIX     = pea_pkg::N_RADIX,
  parameter int unsigned N_DIV_STAGE = pea_pkg::N_DIV_STAGE
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clear_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  fu_instr_t         instr_i,
  input  logic [N_BITS-1:0] op_a_i,
  input  logic [N_BITS-1:0] op_b_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [N_BITS-1:0] res_o
);

  localparam int unsigned BPS   = $clog2(N_RADIX);
  localparam int unsigned CNT_W = (N_DIV_STAGE > 1) ? $clog2(N_DIV_STAGE) : 1;

  if (!DIV_CFG_OK || (N_DIV_STAGE * BPS != N_BITS) || ((1 << BPS) != N_RADIX)) begin : g_cfg_err
    $error("pe_radix16_div: N_DIV_STAGE*log2(N_RADIX) must equal N_BITS");
  end

  div_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_BITS:0]   rem_q, rem_d;
  logic [N_BITS-1:0] dq_q, dq_d, div_q, div_d, res_q, res_d;
  fu_instr_t         instr_q, instr_d;
  logic              qs_q, qs_d, rs_q, rs_d, div0_q, div0_d, ovf_q, ovf_d;

  logic              in_signed, in_a_neg, in_b_neg, in_div0, in_ovf;
  logic [N_BITS-1:0] in_a_mag, in_b_mag;

  assign in_signed = (instr_i == FU_DIV) || (instr_i == FU_REM);
  assign in_a_neg  = in_signed & op_a_i[N_BITS-1];
  assign in_b_neg  = in_signed & op_b_i[N_BITS-1];
  assign in_a_mag  = in_a_neg ? -op_a_i : op_a_i;
  assign in_b_mag  = in_b_neg ? -op_b_i : op_b_i;
  assign in_div0   = (op_b_i == '0);
  assign in_ovf    = in_signed && (op_a_i == {1'b1, {(N_BITS-1){1'b0}}}) && (op_b_i == '1);

  // dq_q starts as |A|; dividend bits leave at the top while quotient digits
  // enter at the bottom, so after the last iteration it holds the quotient.
  logic [N_BITS:0]   st_rem;
  logic [BPS-1:0]    st_q;
  logic [N_BITS-1:0] quo_nxt;

  pe_div_step #(.N_BITS(N_BITS), .BPS(BPS)) u_step (
    .rem_i  (rem_q),
    .div_i  (div_q),
    .bits_i (dq_q[N_BITS-1 -: BPS]),
    .rem_o  (st_rem),
    .q_o    (st_q)
  );

  assign quo_nxt = {dq_q[N_BITS-BPS-1:0], st_q};

  // With a zero divisor the restoring remainder equals |A|, so REM yields A.
  function automatic logic [N_BITS-1:0] fix_res(
    input fu_instr_t ins, input logic div0, input logic ovf,
    input logic [N_BITS-1:0] q_mag, input logic [N_BITS-1:0] r_mag,
    input logic qs, input logic rs);
    logic [N_BITS-1:0] q, r;
    q = qs ? -q_mag : q_mag;
    r = rs ? -r_mag : r_mag;
    case (ins)
      FU_DIV:  fix_res = div0 ? '1 : (ovf ? {1'b1, {(N_BITS-1){1'b0}}} : q);
      FU_DIVU: fix_res = div0 ? '1 : q;
      FU_REM:  fix_res = ovf ? '0 : r;
      default: fix_res = '0;
    endcase
  endfunction

`ifdef MAGE_DIV_EARLY_OUT_EN
  logic in_early;
  assign in_early = in_div0 || in_ovf || (in_a_mag < in_b_mag) ||
                    !((instr_i == FU_DIV) || (instr_i == FU_DIVU) || (instr_i == FU_REM));
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dq_d    = dq_q;
    div_d   = div_q;
    res_d   = res_q;
    instr_d = instr_q;
    qs_d    = qs_q;
    rs_d    = rs_q;
    div0_d  = div0_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (valid_i) begin
        instr_d = instr_i;
        div_d   = in_b_mag;
        dq_d    = in_a_mag;
        rem_d   = '0;
        qs_d    = in_a_neg ^ in_b_neg;
        rs_d    = in_a_neg;
        div0_d  = in_div0;
        ovf_d   = in_ovf;
        cnt_d   = CNT_W'(N_DIV_STAGE - 1);
        state_d = CALC;
`ifdef MAGE_DIV_EARLY_OUT_EN
        if (in_early) begin
          state_d = DONE;
          cnt_d   = '0;
          res_d   = fix_res(instr_i, in_div0, in_ovf, '0, in_a_mag,
                            in_a_neg ^ in_b_neg, in_a_neg);
        end
`endif
      end
      CALC: begin
        rem_d = st_rem;
        dq_d  = quo_nxt;
        if (cnt_q == '0) begin
          state_d = DONE;
          res_d   = fix_res(instr_q, div0_q, ovf_q, quo_nxt, st_rem[N_BITS-1:0], qs_q, rs_q);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dq_q    <= '0;
      div_q   <= '0;
      res_q   <= '0;
      instr_q <= FU_NOP;
      qs_q    <= 1'b0;
      rs_q    <= 1'b0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dq_q    <= dq_d;
      div_q   <= div_d;
      res_q   <= res_d;
      instr_q <= instr_d;
      qs_q    <= qs_d;
      rs_q    <= rs_d;
      div0_q  <= div0_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign res_o   = res_q;

endmodule

// File: tb/tb_pe_radix16_div.sv
// Directed + small random bench for pe_radix16_div with a result/latency scoreboard.
module tb_pe_radix16_div;
  import pea_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0, clear = 1'b0, valid_i = 1'b0, ready_i = 1'b1;
  fu_instr_t   instr = FU_NOP;
  logic [31:0] a = '0, b = '0;
  logic        ready_o, valid_o;
  logic [31:0] res;

  always #5 clk = ~clk;

`ifdef MAGE_DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  pe_radix16_div dut (
    .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear), .valid_i(valid_i), .ready_o(ready_o),
    .instr_i(instr), .op_a_i(a), .op_b_i(b), .valid_o(valid_o), .ready_i(ready_i), .res_o(res)
  );

  typedef struct { logic [31:0] res; int lat; string tag; } exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input string tag, input fu_instr_t ins, input logic [31:0] av,
                      input logic [31:0] bv, input logic [31:0] r, input bit early);
    exp_t e;
    int w;
    w = 0;
    while (!ready_o && w < 50) begin step(); w++; end
    chk({tag, "/ready_in"}, 32'(ready_o), 32'd1);
    e.res = r; e.lat = (EARLY && early) ? 1 : 9; e.tag = tag;
    sb.push_back(e);
    instr = ins; a = av; b = bv; valid_i = 1'b1;
    step();
    valid_i = 1'b0; instr = FU_NOP; a = $urandom; b = $urandom;
  endtask

  task automatic collect(input bit hold);
    exp_t e;
    int lat;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    e = sb.pop_front();
    chk({e.tag, "/busy"}, 32'(ready_o), 32'd0);
    lat = 1;
    while (!valid_o && lat < 40) begin step(); lat++; end
    chk({e.tag, "/res"}, res, e.res);
    chk({e.tag, "/lat"}, 32'(lat), 32'(e.lat));
    if (hold) begin
      for (int k = 0; k < 3; k++) begin
        step();
        chk({e.tag, "/hold_vld"}, 32'(valid_o), 32'd1);
        chk({e.tag, "/hold_res"}, res, e.res);
      end
      ready_i = 1'b1;
    end
    step();
    chk({e.tag, "/ready_after"}, 32'(ready_o), 32'd1);
    chk({e.tag, "/valid_after"}, 32'(valid_o), 32'd0);
  endtask

  task automatic op(input string tag, input fu_instr_t ins, input logic [31:0] av,
                    input logic [31:0] bv, input logic [31:0] r, input bit early);
    send(tag, ins, av, bv, r, early);
    collect(1'b0);
  endtask

  initial begin
    logic [31:0] ra, rb, ma, mb;
    bit seen;

    step(); step();
    chk("reset/ready", 32'(ready_o), 32'd1);
    chk("reset/valid", 32'(valid_o), 32'd0);
    chk("reset/res", res, 32'd0);
    #2 rst_n = 1'b1;
    step();

    op("divu_100_7",   FU_DIVU, 32'd100, 32'd7, 32'd14, 1'b0);
    op("rem_100_7",    FU_REM,  32'd100, 32'd7, 32'd2, 1'b0);
    op("div_m100_7",   FU_DIV,  -32'sd100, 32'd7, 32'hFFFF_FFF2, 1'b0);
    op("rem_m100_7",   FU_REM,  -32'sd100, 32'd7, 32'hFFFF_FFFE, 1'b0);
    op("rem_100_m7",   FU_REM,  32'd100, -32'sd7, 32'd2, 1'b0);
    op("div_7_m2",     FU_DIV,  32'd7, -32'sd2, 32'hFFFF_FFFD, 1'b0);
    op("divu_5_0",     FU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
    op("div_5_0",      FU_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
    op("rem_5_0",      FU_REM,  32'd5, 32'd0, 32'd5, 1'b1);
    op("rem_m5_0",     FU_REM,  -32'sd5, 32'd0, 32'hFFFF_FFFB, 1'b1);
    op("div_min_m1",   FU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    op("rem_min_m1",   FU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);
    op("unsup_add",    FU_ADD,  32'd7, 32'd3, 32'd0, 1'b1);
    op("divu_3_10",    FU_DIVU, 32'd3, 32'd10, 32'd0, 1'b1);
    op("rem_m3_10",    FU_REM,  -32'sd3, 32'd10, 32'hFFFF_FFFD, 1'b1);

    ready_i = 1'b0;
    send("divu_max_1", FU_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0);
    collect(1'b1);

    // Abort a long DIV at cycle 4; nothing may come out of it.
    instr = FU_DIV; a = 32'd1000; b = -32'sd7; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    step(); step(); step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear/valid", 32'(valid_o), 32'd0);
    chk("clear/ready", 32'(ready_o), 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (valid_o) seen = 1'b1;
      step();
    end
    chk("clear/no_output", 32'(seen), 32'd0);
    op("divu_9_3", FU_DIVU, 32'd9, 32'd3, 32'd3, 1'b0);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($urandom_range(1, 32'hFFFF)) : $urandom;
      if (rb == 0) rb = 32'd1;
      op($sformatf("rand_divu%0d", i), FU_DIVU, ra, rb, ra / rb, ra < rb);
    end
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($signed(16'($urandom))) : $urandom;
      if (rb == 0 || rb == 32'hFFFF_FFFF) rb = 32'd3;
      ma = ra[31] ? -ra : ra;
      mb = rb[31] ? -rb : rb;
      op($sformatf("rand_div%0d", i), FU_DIV, ra, rb, 32'($signed(ra) / $signed(rb)), ma < mb);
      op($sformatf("rand_rem%0d", i), FU_REM, ra, rb, 32'($signed(ra) % $signed(rb)), ma < mb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pe_radix16_div.md
# pe_radix16_div

Iterative radix-16 integer divider serving the DIV, DIVU and REM operations of a Mage processing element. It sits directly downstream of the PE operand muxes, taking operand A, operand B and the decoded FU instruction, and feeds its result back to the PE output register. The divider produces 4 quotient bits per cycle over `N_DIV_STAGE` iterations, with valid/ready handshakes on both sides so the PE can stall around it.

## Interface
Parameters:
- `N_BITS`, default `pea_pkg::N_BITS` (32): operand and result width.
- `N_RADIX`, default `pea_pkg::N_RADIX` (16): quotient digit radix. Must be a power of 2.
- `N_DIV_STAGE`, default `pea_pkg::N_DIV_STAGE` (8): iteration count. Must equal `N_BITS/$clog2(N_RADIX)`.

Ports:
- `clk_i`, input, 1: clock.
- `rst_n_i`, input, 1: asynchronous active-low reset.
- `clear_i`, input, 1: synchronous abort. Returns the block to IDLE.
- `valid_i`, input, 1: operands and instruction are valid.
- `ready_o`, output, 1: the divider accepts a new operation.
- `instr_i`, input, `fu_instr_t`: DIV, DIVU or REM. Any other value is unsupported.
- `op_a_i`, input, `N_BITS`: dividend.
- `op_b_i`, input, `N_BITS`: divisor.
- `valid_o`, output, 1: `res_o` is valid.
- `ready_i`, input, 1: the consumer accepts the result.
- `res_o`, output, `N_BITS`: quotient or remainder.

## Operation
- FSM states:
  - IDLE: `ready_o`=1. A cycle with `valid_i` high accepts the operation.
  - CALC: the iteration counter runs from `N_DIV_STAGE-1` down to 0.
  - DONE: `valid_o`=1.
- Transitions:
  - IDLE→CALC on accept.
  - CALC→DONE when the counter reaches 0.
  - DONE→IDLE on `ready_i`.
- On accept, the block latches the following:
  - the magnitudes of A and B (signed for DIV/REM, raw for DIVU);
  - the quotient sign, which is sign(A) XOR sign(B);
  - the remainder sign, which is sign(A);
  - the instruction.
- The partial remainder is an `N_BITS+1`-bit register.
- Each CALC cycle performs 4 chained radix-2 restoring steps. Each step shifts in the next dividend MSB, trial-subtracts the divisor and keeps the difference when it is non-negative. Quotient bits enter the quotient register MSB-first.
- Sign fix-up is applied on the CALC→DONE edge. The quotient is negated if the quotient sign is 1; the remainder is negated if the remainder sign is 1. `res_o` is registered.
- Special cases, following RISC-V semantics:
  - Divide by zero: DIV and DIVU return all-ones. REM returns A.
  - DIV of INT_MIN by -1 returns INT_MIN. REM of INT_MIN by -1 returns 0.
  - Unsupported instruction: the operation is accepted and returns 0.
- `clear_i` takes priority in every state: the FSM goes to IDLE and `valid_o` drops the next cycle. A handshake in the same cycle as `clear_i` is discarded.
- Reset values: FSM=IDLE, `ready_o`=1 (combinational from IDLE), `valid_o`=0, `res_o`=0, counter=0, internal registers=0.
- Reset asserted mid-operation drops the operation immediately, with no output.

## Timing
- The accept cycle is cycle 0. `valid_o` rises at cycle `N_DIV_STAGE+1`, which is 9 with defaults.
- `res_o` and `valid_o` hold stable while `ready_i`=0.
- `ready_o` rises the cycle after the output handshake. The minimum initiation interval is 10 cycles with defaults.
- `ready_o` is never high in CALC or DONE. There is no combinational path from `valid_i` to `valid_o` or from `ready_i` to `ready_o`.

## Configuration
- `MAGE_DIV_EARLY_OUT_EN` defined: special cases (divide by zero, INT_MIN/-1, unsupported instruction) and the case |A| < |B| skip CALC. They go IDLE→DONE, with `valid_o` at cycle 1. For |A| < |B|, the quotient is 0 and the remainder is A.
- Macro undefined: every operation takes the full `N_DIV_STAGE` iterations. Special-case results override the datapath result at the DONE edge. Latency is always `N_DIV_STAGE+1`.

## Structure
- Add the following to `pea_pkg`:
  - `div_state_t` enum (IDLE, CALC, DONE);
  - `DIV_BITS_PER_STAGE = $clog2(N_RADIX)`;
  - an elaboration-time check that `N_DIV_STAGE*DIV_BITS_PER_STAGE == N_BITS`.
- Sub-module `pe_div_step`: purely combinational. It takes the partial remainder, the divisor and the next `DIV_BITS_PER_STAGE` dividend bits, and returns the new partial remainder plus the quotient digit. It is instantiated once.

## Test plan
- DIVU 100/7 → `res_o`=14 with `valid_o` at cycle 9. REM 100/7 → 2.
- DIV -100/7 → -14 (0xFFFFFFF2). REM -100/7 → -2. REM 100/-7 → 2.
- DIVU 5/0 → 0xFFFFFFFF. REM 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM of the same operands → 0.
- DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF; `ready_i` held low for 3 cycles → `res_o` stable and `valid_o` high throughout. Then `ready_o`=1 one cycle after the handshake.
- `clear_i` pulsed at cycle 4 of a DIV → no `valid_o`, `ready_o`=1 the next cycle. A following DIVU 9/3 → 3.
- With `MAGE_DIV_EARLY_OUT_EN` defined: DIVU 3/10 → `res_o`=0 at cycle 1. Without the macro → the same result at cycle 9.
